// File: rtl/enhance_pkg.sv
// enhance_pkg: shared mode encoding and width helpers
// for the pixel_enhance_stream point-operation engine.
package enhance_pkg;

  typedef enum logic [1:0] {
    MODE_BRIGHT   = 2'd0,
    MODE_CONTRAST = 2'd1,
    MODE_THRESH   = 2'd2,
    MODE_INVERT   = 2'd3
  } mode_e;

  localparam int N_CH = 3;

  function automatic int pix_w(input int dw);
    return N_CH * dw;
  endfunction

  function automatic int sum_w(input int dw);
    return dw + 2;
  endfunction

  function automatic int prod_w(input int dw);
    return 2 * dw + 2;
  endfunction

  function automatic int sat_hi(input int dw);
    return (1 << dw) - 1;
  endfunction

endpackage

// File: rtl/enhance_pixel.sv
// enhance_pixel: one pixel's two-stage datapath
// (stage 1 luma/products, stage 2 clamped result).
module enhance_pixel
  import enhance_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int FRAC_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld1,
  input  logic                  ld2,
  input  logic [3*DATA_W-1:0]   pix_i,
  input  logic [1:0]            mode_i,
  input  logic [DATA_W-1:0]     bright_i,
  input  logic                  sign_i,
  input  logic [DATA_W-1:0]     thresh_i,
  input  logic [DATA_W-1:0]     cf_i,
  input  logic [DATA_W-1:0]     mid_i,
  output logic [DATA_W-1:0]     luma_o,
  output logic [3*DATA_W-1:0]   pix_o
);

  localparam int SW   = sum_w(DATA_W);
  localparam int PW   = prod_w(DATA_W);
  localparam int MAXV = sat_hi(DATA_W);
  localparam logic signed [PW-1:0] HI = PW'(MAXV);

  mode_e                mode_d, mode_q;
  logic [DATA_W-1:0]    mid_d, mid_q;
  logic [DATA_W-1:0]    luma_d, luma_q;
  logic                 gt_d, gt_q;
  logic signed [PW-1:0] bri_d [N_CH];
  logic signed [PW-1:0] bri_q [N_CH];
  logic signed [PW-1:0] prod_d [N_CH];
  logic signed [PW-1:0] prod_q [N_CH];
  logic [3*DATA_W-1:0]  out_d, out_q;

  logic [SW-1:0]        sum;
  logic signed [PW-1:0] p_s, b_s, m_s, c_s;
  logic signed [PW-1:0] m2, l_s, t;

  always_comb begin
    mode_d = mode_q;
    mid_d  = mid_q;
    luma_d = luma_q;
    gt_d   = gt_q;
    bri_d  = bri_q;
    prod_d = prod_q;
    out_d  = out_q;
    sum = SW'(pix_i[0 +: DATA_W])
        + SW'(pix_i[DATA_W +: DATA_W])
        + SW'(pix_i[2*DATA_W +: DATA_W]);
    p_s = '0;
    b_s = PW'(bright_i);
    m_s = PW'(mid_i);
    c_s = PW'(cf_i);
    m2  = PW'(mid_q);
    l_s = PW'(luma_q);
    t   = '0;
    if (ld1) begin
      mode_d = mode_e'(mode_i);
      mid_d  = mid_i;
      luma_d = DATA_W'(sum / SW'(3));
      gt_d   = luma_d > thresh_i;
      for (int c = 0; c < N_CH; c++) begin
        p_s       = PW'(pix_i[c*DATA_W +: DATA_W]);
        bri_d[c]  = sign_i ? p_s + b_s : p_s - b_s;
        prod_d[c] = (p_s - m_s) * c_s;
      end
    end
    if (ld2) begin
      for (int c = 0; c < N_CH; c++) begin
        unique case (mode_q)
          MODE_BRIGHT:   t = bri_q[c];
          MODE_CONTRAST: t = m2 + (prod_q[c] >>> FRAC_W);
          MODE_THRESH:   t = gt_q ? HI : '0;
          MODE_INVERT:   t = HI - l_s;
        endcase
        out_d[c*DATA_W +: DATA_W] =
          (t < 0)  ? '0 :
          (t > HI) ? DATA_W'(MAXV) : t[DATA_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= MODE_BRIGHT;
      mid_q  <= '0;
      luma_q <= '0;
      gt_q   <= 1'b0;
      bri_q  <= '{default: '0};
      prod_q <= '{default: '0};
      out_q  <= '0;
    end else begin
      mode_q <= mode_d;
      mid_q  <= mid_d;
      luma_q <= luma_d;
      gt_q   <= gt_d;
      bri_q  <= bri_d;
      prod_q <= prod_d;
      out_q  <= out_d;
    end
  end

  assign luma_o = luma_q;
  assign pix_o  = out_q;

endmodule

// File: rtl/pixel_enhance_stream.sv
// pixel_enhance_stream: streaming brightness/contrast/threshold/invert
// with valid/ready and line/frame markers; ENHANCE_STATS_EN adds luma min/max.
module pixel_enhance_stream
  import enhance_pkg::*;
#(
  parameter int PIX_PER_CLK = 2,
  parameter int DATA_W      = 8,
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 426,
  parameter int FRAC_W      = 4
) (
  input  logic                            HCLK,
  input  logic                            HRESET,
  input  logic [1:0]                      cfg_mode,
  input  logic [DATA_W-1:0]               cfg_bright,
  input  logic                            cfg_sign,
  input  logic [DATA_W-1:0]               cfg_thresh,
  input  logic [DATA_W-1:0]               cfg_cf,
  input  logic [DATA_W-1:0]               cfg_mid,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [PIX_PER_CLK*3*DATA_W-1:0] s_data,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [PIX_PER_CLK*3*DATA_W-1:0] m_data,
  output logic                            m_sol,
  output logic                            m_eol,
  output logic                            m_eof,
  output logic [DATA_W-1:0]               stat_min,
  output logic [DATA_W-1:0]               stat_max,
  output logic                            stat_valid
);

  localparam int BPL = WIDTH / PIX_PER_CLK;
  localparam int CW  = $clog2(BPL + 1);
  localparam int RW  = $clog2(HEIGHT + 1);
  localparam int PXW = pix_w(DATA_W);

  logic [CW-1:0]     col_d, col_q;
  logic [RW-1:0]     row_d, row_q;
  logic              s1_v_d, s1_v_q, s2_v_d, s2_v_q;
  logic [2:0]        s1_mk_d, s1_mk_q, s2_mk_d, s2_mk_q;
  logic [1:0]        sh_mode_d, sh_mode_q;
  logic [DATA_W-1:0] sh_bright_d, sh_bright_q;
  logic              sh_sign_d, sh_sign_q;
  logic [DATA_W-1:0] sh_thresh_d, sh_thresh_q;
  logic [DATA_W-1:0] sh_cf_d, sh_cf_q;
  logic [DATA_W-1:0] sh_mid_d, sh_mid_q;

  logic              adv1, adv2, acc, ld2;
  logic              first, eol, eof;
  logic [1:0]        e_mode;
  logic [DATA_W-1:0] e_bright, e_thresh, e_cf, e_mid;
  logic              e_sign;
  logic [DATA_W-1:0] luma [PIX_PER_CLK];

  always_comb begin
    adv2  = !s2_v_q || m_ready;
    adv1  = !s1_v_q || adv2;
    acc   = s_valid && adv1;
    ld2   = adv2 && s1_v_q;
    first = (col_q == '0) && (row_q == '0);
    eol   = col_q == CW'(BPL - 1);
    eof   = eol && (row_q == RW'(HEIGHT - 1));
    // The frame's first beat uses live config; the rest use the shadow.
    e_mode   = first ? cfg_mode   : sh_mode_q;
    e_bright = first ? cfg_bright : sh_bright_q;
    e_sign   = first ? cfg_sign   : sh_sign_q;
    e_thresh = first ? cfg_thresh : sh_thresh_q;
    e_cf     = first ? cfg_cf     : sh_cf_q;
    e_mid    = first ? cfg_mid    : sh_mid_q;

    col_d       = col_q;
    row_d       = row_q;
    s1_mk_d     = s1_mk_q;
    s2_mk_d     = s2_mk_q;
    sh_mode_d   = sh_mode_q;
    sh_bright_d = sh_bright_q;
    sh_sign_d   = sh_sign_q;
    sh_thresh_d = sh_thresh_q;
    sh_cf_d     = sh_cf_q;
    sh_mid_d    = sh_mid_q;
    s1_v_d      = adv1 ? s_valid : s1_v_q;
    s2_v_d      = adv2 ? s1_v_q : s2_v_q;

    if (acc) begin
      s1_mk_d = {col_q == '0, eol, eof};
      if (eol) begin
        col_d = '0;
        row_d = eof ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      if (first) begin
        sh_mode_d   = cfg_mode;
        sh_bright_d = cfg_bright;
        sh_sign_d   = cfg_sign;
        sh_thresh_d = cfg_thresh;
        sh_cf_d     = cfg_cf;
        sh_mid_d    = cfg_mid;
      end
    end
    if (ld2) s2_mk_d = s1_mk_q;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      col_q       <= '0;
      row_q       <= '0;
      s1_v_q      <= 1'b0;
      s2_v_q      <= 1'b0;
      s1_mk_q     <= '0;
      s2_mk_q     <= '0;
      sh_mode_q   <= '0;
      sh_bright_q <= '0;
      sh_sign_q   <= 1'b0;
      sh_thresh_q <= '0;
      sh_cf_q     <= '0;
      sh_mid_q    <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      s1_v_q      <= s1_v_d;
      s2_v_q      <= s2_v_d;
      s1_mk_q     <= s1_mk_d;
      s2_mk_q     <= s2_mk_d;
      sh_mode_q   <= sh_mode_d;
      sh_bright_q <= sh_bright_d;
      sh_sign_q   <= sh_sign_d;
      sh_thresh_q <= sh_thresh_d;
      sh_cf_q     <= sh_cf_d;
      sh_mid_q    <= sh_mid_d;
    end
  end

  for (genvar k = 0; k < PIX_PER_CLK; k++) begin : g_pix
    enhance_pixel #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W)
    ) u_pix (
      .clk      (HCLK),
      .rst      (HRESET),
      .ld1      (acc),
      .ld2      (ld2),
      .pix_i    (s_data[k*PXW +: PXW]),
      .mode_i   (e_mode),
      .bright_i (e_bright),
      .sign_i   (e_sign),
      .thresh_i (e_thresh),
      .cf_i     (e_cf),
      .mid_i    (e_mid),
      .luma_o   (luma[k]),
      .pix_o    (m_data[k*PXW +: PXW])
    );
  end

  assign s_ready = adv1;
  assign m_valid = s2_v_q;
  assign m_sol   = s2_mk_q[2];
  assign m_eol   = s2_mk_q[1];
  assign m_eof   = s2_mk_q[0];

`ifdef ENHANCE_STATS_EN
  logic [DATA_W-1:0] trk_min_d, trk_min_q, trk_max_d, trk_max_q;
  logic [DATA_W-1:0] st_min_d, st_min_q, st_max_d, st_max_q;
  logic              st_v_d, st_v_q;
  logic [DATA_W-1:0] bmin, bmax;
  logic              eof_hs;

  always_comb begin
    bmin = '1;
    bmax = '0;
    for (int k = 0; k < PIX_PER_CLK; k++) begin
      if (luma[k] < bmin) bmin = luma[k];
      if (luma[k] > bmax) bmax = luma[k];
    end
    eof_hs    = s2_v_q && m_ready && s2_mk_q[0];
    trk_min_d = trk_min_q;
    trk_max_d = trk_max_q;
    st_min_d  = st_min_q;
    st_max_d  = st_max_q;
    st_v_d    = eof_hs;
    // A beat entering stage 2 with the eof handshake opens the next frame.
    if (eof_hs) begin
      st_min_d  = trk_min_q;
      st_max_d  = trk_max_q;
      trk_min_d = '1;
      trk_max_d = '0;
    end
    if (ld2) begin
      if (bmin < trk_min_d) trk_min_d = bmin;
      if (bmax > trk_max_d) trk_max_d = bmax;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      trk_min_q <= '1;
      trk_max_q <= '0;
      st_min_q  <= '1;
      st_max_q  <= '0;
      st_v_q    <= 1'b0;
    end else begin
      trk_min_q <= trk_min_d;
      trk_max_q <= trk_max_d;
      st_min_q  <= st_min_d;
      st_max_q  <= st_max_d;
      st_v_q    <= st_v_d;
    end
  end

  assign stat_min   = st_min_q;
  assign stat_max   = st_max_q;
  assign stat_valid = st_v_q;
`else
  logic [DATA_W-1:0] unused_luma;

  always_comb begin
    unused_luma = '0;
    for (int k = 0; k < PIX_PER_CLK; k++) unused_luma |= luma[k];
  end

  assign stat_min   = '0;
  assign stat_max   = '0;
  assign stat_valid = 1'b0;
`endif

endmodule
